// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the command-driven up/down count sequencer.
package count_seq_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PASS_W = 4;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_WRAP    = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

endpackage

// File: rtl/count_sequencer_if.sv
// Command channel (valid/ready plus payload) between a host and the count sequencer.
interface count_sequencer_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned PW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [1:0]    cmd_mode;
  logic [W-1:0]  cmd_start;
  logic [W-1:0]  cmd_limit;
  logic [PW-1:0] cmd_passes;

  modport master (
    output cmd_valid, cmd_dir, cmd_mode, cmd_start, cmd_limit, cmd_passes,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_mode, cmd_start, cmd_limit, cmd_passes,
    output cmd_ready
  );
endinterface

// File: rtl/count_sequencer_udcount_core.sv
// W-bit up/down counter register; load has priority over a step, arithmetic wraps modulo 2^W.
module udcount_core #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? W'(count + W'(1)) : W'(count - W'(1));
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequencer FSM: accepts one command per run and steps the counter core toward the limit,
// ending the run (one-shot) or repeating it (wrap / bounce) for a number of passes.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned W  = CNT_W,
  parameter int unsigned PW = PASS_W
) (
  input  logic             clock,
  input  logic             reset,
  count_sequencer_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  output logic [W-1:0]     count,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d, cmd_mode_in;
  logic [W-1:0]  origin_q, origin_d, target_q, target_d;
  logic [PW-1:0] passes_q, passes_d, pass_cnt_q, pass_cnt_d, pass_inc;
  logic          up_down_q, up_down_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic          accept, at_target, last_pass;
  logic          cnt_en, cnt_load;
  logic [W-1:0]  cnt_load_val;

  assign cmd_mode_in   = mode_e'(cmd.cmd_mode);
  assign accept        = cmd.cmd_valid & ready_q;
  assign at_target     = (count == target_q);
  assign pass_inc      = PW'(pass_cnt_q + PW'(1));
  // A zero pass count never matches, so wrap/bounce runs continue until aborted.
  assign last_pass     = (passes_q != '0) && (pass_inc == passes_q);

  assign cmd.cmd_ready = ready_q;
  assign up_down       = up_down_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  udcount_core #(.W(W)) u_core (
    .clock    (clock),
    .reset    (reset),
    .en       (cnt_en),
    .up       (up_down_q),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (count)
  );

  // State, latched command and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ONESHOT;
      origin_q   <= '0;
      target_q   <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      up_down_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      origin_q   <= origin_d;
      target_q   <= target_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      up_down_q  <= up_down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  // Next state and counter control; priority abort > pause > end-of-pass > step.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    origin_d     = origin_q;
    target_d     = target_q;
    passes_d     = passes_q;
    pass_cnt_d   = pass_cnt_q;
    up_down_d    = up_down_q;
    err_d        = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = origin_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_mode_in == MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            mode_d       = cmd_mode_in;
            origin_d     = cmd.cmd_start;
            target_d     = cmd.cmd_limit;
            passes_d     = cmd.cmd_passes;
            pass_cnt_d   = '0;
            up_down_d    = cmd.cmd_dir;
            cnt_load     = 1'b1;
            cnt_load_val = cmd.cmd_start;
            state_d      = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (at_target) begin
          unique case (mode_q)
            MODE_WRAP: begin
              pass_cnt_d = pass_inc;
              if (last_pass) begin
                state_d = ST_DONE;
              end else begin
                cnt_load = 1'b1;
              end
            end
            MODE_BOUNCE: begin
              pass_cnt_d = pass_inc;
              if (last_pass) begin
                state_d = ST_DONE;
              end else begin
                up_down_d = ~up_down_q;
                origin_d  = target_q;
                target_d  = origin_q;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d  = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: a trajectory model predicts per-cycle count/direction
// and end events; a negedge monitor pops and compares whatever the DUT presents.
module tb_count_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 4;

  localparam int K_TRACE = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;
  localparam int K_STOP  = 3;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int dir;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         up_down, busy, done, err;

  count_sequencer_if #(.W(W), .PW(PW)) cmd_if ();

  count_sequencer #(.W(W), .PW(PW)) dut (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd_if),
    .pause   (pause),
    .abort   (abort),
    .count   (count),
    .up_down (up_down),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   traj_c[$];
  int   traj_d[$];
  int   exp_count = 0;
  int   exp_dir = 0;
  bit   prev_busy = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int cnt, input int dir);
    exp_t e;
    e.kind = kind; e.cyc = c; e.cnt = cnt; e.dir = dir;
    q.push_back(e);
  endtask

  // Monitor: classify what the DUT presents this cycle and compare with the scoreboard head.
  always @(negedge clock) begin
    int   kind;
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (err === 1'b1)       kind = K_ERR;
      else if (done === 1'b1) kind = K_DONE;
      else if (busy === 1'b1) kind = K_TRACE;
      else if (prev_busy)     kind = K_STOP;
      else                    kind = -1;
      if (kind < 0) begin
        chk("idle_ready", int'(cmd_if.cmd_ready), 1);
      end else if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("count", int'(count), e.cnt);
        chk("up_down", int'(up_down), e.dir);
        chk("cmd_ready", int'(cmd_if.cmd_ready), (e.kind == K_ERR || e.kind == K_STOP) ? 1 : 0);
      end
      prev_busy = busy;
    end
  end

  // Logical trajectory of a run: each pass lists origin..target; bounce reverses per pass.
  function automatic void build(input logic dir, input logic [1:0] mode,
                                input logic [W-1:0] st, input logic [W-1:0] lim,
                                input logic [PW-1:0] passes);
    logic [W-1:0] o, t, diff, v;
    logic         d;
    int           np;
    traj_c.delete();
    traj_d.delete();
    o = st; t = lim; d = dir;
    if (mode == 2'b00)      np = 1;
    else if (passes == '0)  np = 40;
    else                    np = int'(passes);
    for (int p = 0; p < np; p++) begin
      diff = d ? W'(t - o) : W'(o - t);
      for (int k = 0; k <= int'(diff); k++) begin
        v = d ? W'(o + W'(k)) : W'(o - W'(k));
        traj_c.push_back(int'(v));
        traj_d.push_back(int'(d));
      end
      if (mode == 2'b10) begin
        v = o; o = t; t = v; d = ~d;
      end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("idle_wait", int'(cmd_if.cmd_ready), 1);
  endtask

  task automatic drive_cmd(input logic dir, input logic [1:0] mode,
                           input logic [W-1:0] st, input logic [W-1:0] lim,
                           input logic [PW-1:0] passes);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_mode   = mode;
    cmd_if.cmd_start  = st;
    cmd_if.cmd_limit  = lim;
    cmd_if.cmd_passes = passes;
  endtask

  task automatic illegal_cmd();
    wait_idle();
    drive_cmd(1'($urandom), 2'b11, W'($urandom), W'($urandom), PW'($urandom));
    push(K_ERR, cyc + 1, exp_count, exp_dir);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // One legal run; pause/abort/reset are decided per displayed cycle (rc counts cycles in the run).
  task automatic run_cmd(input logic dir, input logic [1:0] mode,
                         input logic [W-1:0] st, input logic [W-1:0] lim,
                         input logic [PW-1:0] passes, input int pause_pct,
                         input int pause_at, input int pause_len,
                         input int abort_at, input int reset_at, input bit hold_other);
    int i, rc, ecyc, last;
    bit paused, pv, av;
    build(dir, mode, st, lim, passes);
    last = traj_c.size() - 1;
    wait_idle();
    drive_cmd(dir, mode, st, lim, passes);
    ecyc = cyc + 1;
    push(K_TRACE, ecyc, traj_c[0], traj_d[0]);
    step();
    cmd_if.cmd_valid = hold_other;
    cmd_if.cmd_mode  = 2'b11;
    i = 0; rc = 0; paused = 1'b0;
    forever begin
      if (rc == reset_at) begin
        reset = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_up_down", int'(up_down), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        q.delete();
        cmd_if.cmd_valid = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        step();
        step();
        reset = 1'b1;
        exp_count = 0;
        exp_dir = 0;
        return;
      end
      pv = (rc >= pause_at && rc < pause_at + pause_len) ||
           (int'($urandom_range(99)) < pause_pct);
      av = (rc == abort_at);
      pause = pv;
      abort = av;
      if (av) begin
        push(K_STOP, ecyc + 1, traj_c[i], traj_d[i]);
        break;
      end
      if (paused) begin
        if (!pv) paused = 1'b0;
      end else if (pv) begin
        paused = 1'b1;
      end else if (i == last) begin
        push(K_DONE, ecyc + 1, traj_c[i], traj_d[i]);
        break;
      end else begin
        i++;
      end
      push(K_TRACE, ecyc + 1, traj_c[i], traj_d[i]);
      step();
      ecyc++;
      rc++;
    end
    exp_count = traj_c[i];
    exp_dir   = traj_d[i];
    cmd_if.cmd_valid = 1'b0;
    step();
    pause = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    m;
    logic [PW-1:0] np;
    int            ab;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_mode   = 2'b00;
    cmd_if.cmd_start  = '0;
    cmd_if.cmd_limit  = '0;
    cmd_if.cmd_passes = '0;
    step();
    step();
    chk("reset_count", int'(count), 0);
    chk("reset_up_down", int'(up_down), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ready", int'(cmd_if.cmd_ready), 1);
    reset = 1'b1;
    step();

    // Directed scenarios.
    run_cmd(1'b1, 2'b00, 4'd3, 4'd7, 4'd0, 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b0, 2'b00, 4'd1, 4'd14, 4'd0, 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b1, 2'b01, 4'd2, 4'd4, 4'd2, 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b1, 2'b10, 4'd5, 4'd7, 4'd2, 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b1, 2'b00, 4'd3, 4'd8, 4'd0, 0, 2, 3, -1, -1, 1'b0);
    run_cmd(1'b1, 2'b00, 4'd6, 4'd12, 4'd0, 0, -1, 0, 3, -1, 1'b1);
    illegal_cmd();
    run_cmd(1'b0, 2'b00, 4'd9, 4'd9, 4'd0, 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b1, 2'b01, 4'd14, 4'd1, 4'd0, 0, -1, 0, 25, -1, 1'b1);
    run_cmd(1'b0, 2'b10, 4'd15, 4'd15, 4'd3, 0, -1, 0, -1, -1, 1'b0);
    illegal_cmd();

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(9) == 0) begin
        illegal_cmd();
      end else begin
        m  = 2'($urandom_range(2));
        np = PW'($urandom_range(3));
        ab = ($urandom_range(4) == 0) ? int'($urandom_range(20)) : -1;
        if (m != 2'b00 && np == '0) ab = int'($urandom_range(1, 30));
        run_cmd(1'($urandom), m, W'($urandom), W'($urandom), np,
                int'($urandom_range(15)), -1, 0, ab, -1, 1'($urandom));
      end
    end

    run_cmd(1'b1, 2'b00, 4'd0, 4'd15, 4'd0, 0, -1, 0, -1, 5, 1'b0);
    run_cmd(1'b0, 2'b01, 4'd4, 4'd1, 4'd1, 0, -1, 0, -1, -1, 1'b0);

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
